// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: arbiter FSM encodings, response and protection codes.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Anything other than OKAY is reported to the requester as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_reg_arbiter_if.sv
// AXI4-Lite master/slave bundle between the arbiter and the register slave.
interface axil_reg_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 2
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;

    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;

    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;

    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axil_reg_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; on contention the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            last_grant_d = grant[1];
        end
    end

    // Resetting to 1 hands the first contention to requester 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Shares one AXI4-Lite master port between two req/ack requesters, one transaction in flight.
module axil_reg_arbiter
    import axil_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 2
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [1:0]                          i_req_valid,
    input  logic [1:0]                          i_req_we,
    input  logic [2*C_AXI_ADDR_WIDTH-1:0]       i_req_addr,
    input  logic [2*C_AXI_DATA_WIDTH-1:0]       i_req_wdata,
    input  logic [2*(C_AXI_DATA_WIDTH/8)-1:0]   i_req_wstrb,
    output logic [1:0]                          o_req_ack,
    output logic                                o_req_err,
    output logic [C_AXI_DATA_WIDTH-1:0]         o_req_rdata,
    axil_reg_arbiter_if.master                  axi
);

    localparam int unsigned DW = C_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_AXI_ADDR_WIDTH;
    localparam int unsigned SW = DW / 8;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic [1:0]    ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [1:0]    req_eff_c;
    logic [1:0]    grant_c;
    logic          advance_c;
    logic          aw_hs_c;
    logic          w_hs_c;

    // A held request is invisible during its ack cycle so it cannot be granted twice.
    assign req_eff_c = (ack_q != 2'b00) ? 2'b00 : i_req_valid;
    assign advance_c = (state_q == ST_IDLE) && (req_eff_c != 2'b00);
    assign aw_hs_c   = awvalid_q && axi.awready;
    assign w_hs_c    = wvalid_q && axi.wready;

    rr_arbiter2 u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     (req_eff_c),
        .advance (advance_c),
        .grant   (grant_c)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 2'b00;
        err_d     = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (advance_c) begin
                    gnt_d   = grant_c[1];
                    addr_d  = grant_c[1] ? i_req_addr[AW +: AW]  : i_req_addr[0 +: AW];
                    wdata_d = grant_c[1] ? i_req_wdata[DW +: DW] : i_req_wdata[0 +: DW];
                    wstrb_d = grant_c[1] ? i_req_wstrb[SW +: SW] : i_req_wstrb[0 +: SW];
                    if (i_req_we[grant_c[1]]) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            // Address and data channels complete independently, in either order.
            ST_WRITE: begin
                aw_done_d = aw_done_q || aw_hs_c;
                w_done_d  = w_done_q || w_hs_c;
                awvalid_d = awvalid_q && !aw_hs_c;
                wvalid_d  = wvalid_q && !w_hs_c;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WRESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            ST_WRESP: begin
                if (axi.bvalid) begin
                    state_d      = ST_IDLE;
                    bready_d     = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    err_d        = resp_is_err(axi.bresp);
                end
            end

            ST_RADDR: begin
                if (axi.arready) begin
                    state_d   = ST_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end

            ST_RDATA: begin
                if (axi.rvalid) begin
                    state_d      = ST_IDLE;
                    rready_d     = 1'b0;
                    rdata_d      = axi.rdata;
                    ack_d[gnt_q] = 1'b1;
                    err_d        = resp_is_err(axi.rresp);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Reset clears every valid/ready immediately, abandoning any transaction in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 2'b00;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = AXI_PROT_DEFAULT;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = AXI_PROT_DEFAULT;
    assign axi.rready  = rready_q;

    assign o_req_ack   = ack_q;
    assign o_req_err   = err_q;
    assign o_req_rdata = rdata_q;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter against a small 4x32 AXI4-Lite register slave model.
module tb_axil_reg_arbiter;
    import axil_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [2*SW-1:0]   req_wstrb;
    logic [1:0]        req_ack;
    logic              req_err;
    logic [DW-1:0]     req_rdata;

    int checks = 0;
    int errors = 0;

    axil_reg_arbiter_if #(.DW(DW), .AW(AW)) axi ();

    axil_reg_arbiter #(
        .C_AXI_DATA_WIDTH (DW),
        .C_AXI_ADDR_WIDTH (AW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_wstrb (req_wstrb),
        .o_req_ack   (req_ack),
        .o_req_err   (req_err),
        .o_req_rdata (req_rdata),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    // ---------------- register slave model ----------------
    logic [DW-1:0] regs [4];
    int unsigned   aw_delay;
    logic          r_err_inj;
    int unsigned   aw_wait;
    logic          aw_got, w_got, bvalid_s, rvalid_s;
    logic [AW-1:0] aw_addr_s;
    logic [DW-1:0] w_data_s, rdata_s;
    logic [SW-1:0] w_strb_s;
    logic [1:0]    rresp_s;
    logic          aw_hs, w_hs, ar_hs, aw_have, w_have;
    logic [AW-1:0] a_use;
    logic [DW-1:0] d_use;
    logic [SW-1:0] s_use;

    assign axi.awready = axi.awvalid && !aw_got && (aw_wait >= aw_delay);
    assign axi.wready  = axi.wvalid && !w_got;
    assign axi.bvalid  = bvalid_s;
    assign axi.bresp   = AXI_RESP_OKAY;
    assign axi.arready = !rvalid_s;
    assign axi.rvalid  = rvalid_s;
    assign axi.rdata   = rdata_s;
    assign axi.rresp   = rresp_s;

    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign ar_hs   = axi.arvalid && axi.arready;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign a_use   = aw_hs ? axi.awaddr : aw_addr_s;
    assign d_use   = w_hs ? axi.wdata : w_data_s;
    assign s_use   = w_hs ? axi.wstrb : w_strb_s;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < int'(SW); b++) begin
            if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait   <= 0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            bvalid_s  <= 1'b0;
            rvalid_s  <= 1'b0;
            aw_addr_s <= '0;
            w_data_s  <= '0;
            w_strb_s  <= '0;
            rdata_s   <= '0;
            rresp_s   <= AXI_RESP_OKAY;
        end else begin
            aw_wait <= (axi.awvalid && !aw_hs) ? aw_wait + 1 : 0;
            if (aw_hs) aw_addr_s <= axi.awaddr;
            if (w_hs) begin
                w_data_s <= axi.wdata;
                w_strb_s <= axi.wstrb;
            end
            if (aw_have && w_have && !bvalid_s) begin
                regs[a_use] <= merge(regs[a_use], d_use, s_use);
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
                bvalid_s    <= 1'b1;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
                if (bvalid_s && axi.bready) bvalid_s <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_s <= 1'b1;
                rdata_s  <= regs[axi.araddr];
                rresp_s  <= r_err_inj ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (rvalid_s && axi.rready) begin
                rvalid_s <= 1'b0;
            end
        end
    end

    // Channel activity counters
    logic mon_clr;
    int   awv_cnt, wv_cnt, b_cnt;
    always_ff @(posedge clk) begin
        if (mon_clr) begin
            awv_cnt <= 0;
            wv_cnt  <= 0;
            b_cnt   <= 0;
        end else begin
            if (axi.awvalid) awv_cnt <= awv_cnt + 1;
            if (axi.wvalid)  wv_cnt  <= wv_cnt + 1;
            if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[idx]          = v;
        req_we[idx]             = we;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
        req_wstrb[idx*SW +: SW] = s;
    endtask

    task automatic wait_ack(output logic [1:0] a, output logic [31:0] rd, output logic e);
        int n;
        n = 0;
        tick();
        while (req_ack == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("ack_seen", 32'(req_ack != 2'b00), 32'd1);
        a  = req_ack;
        rd = req_rdata;
        e  = req_err;
    endtask

    task automatic single(input int idx, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [SW-1:0] strb,
                          output logic [1:0] a, output logic [31:0] rd, output logic e);
        set_req(idx, 1'b1, we, addr, data, strb);
        wait_ack(a, rd, e);
        req_valid[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  a;
        logic [31:0] rd;
        logic        e;
        logic [1:0]  ack_or;

        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        aw_delay  = 0;
        r_err_inj = 1'b0;
        mon_clr   = 1'b1;
        repeat (2) tick();

        check("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
        check("rst_ack_err", 32'({req_ack, req_err}), 32'd0);
        check("rst_rdata", req_rdata, 32'd0);
        check("rst_addr_strb", 32'({axi.awaddr, axi.araddr, axi.wstrb}), 32'd0);
        check("rst_wdata", axi.wdata, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait write: aw/w in cycle 1, bready in cycle 2, ack in cycle 3
        set_req(0, 1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF);
        tick();
        check("wr_c1_awv_wv", 32'({axi.awvalid, axi.wvalid}), 32'd3);
        check("wr_c1_awaddr", 32'(axi.awaddr), 32'd2);
        check("wr_c1_wdata", axi.wdata, 32'hDEADBEEF);
        tick();
        check("wr_c2_chan", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'd1);
        check("wr_c2_noack", 32'(req_ack), 32'd0);
        tick();
        check("wr_c3_ack", 32'(req_ack), 32'd1);
        check("wr_c3_err", 32'(req_err), 32'd0);
        check("wr_reg2", regs[2], 32'hDEADBEEF);
        req_valid[0] = 1'b0;

        // Preload remaining registers
        single(1, 1'b1, 2'd1, 32'h22222222, 4'hF, a, rd, e);
        check("pre1_ack", 32'(a), 32'd2);
        single(1, 1'b1, 2'd3, 32'h44444444, 4'hF, a, rd, e);
        single(0, 1'b1, 2'd0, 32'h11111111, 4'hF, a, rd, e);
        check("pre0_ack", 32'(a), 32'd1);

        // Contention after reset: 0, then 1, then 0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 2'd3, 32'h0, 4'h0);
        wait_ack(a, rd, e);
        check("rr1_ack", 32'(a), 32'd1);
        check("rr1_rdata", rd, 32'h22222222);
        set_req(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        wait_ack(a, rd, e);
        check("rr2_ack", 32'(a), 32'd2);
        check("rr2_rdata", rd, 32'h44444444);
        set_req(1, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0);
        wait_ack(a, rd, e);
        check("rr3_ack", 32'(a), 32'd1);
        check("rr3_rdata", rd, 32'h11111111);
        req_valid[0] = 1'b0;
        wait_ack(a, rd, e);
        check("rr4_ack", 32'(a), 32'd2);
        check("rr4_rdata", rd, 32'hDEADBEEF);
        req_valid[1] = 1'b0;

        // AW delayed three cycles, W accepted at once
        aw_delay = 3;
        tick();
        mon_clr = 1'b0;
        single(0, 1'b1, 2'd0, 32'h55555555, 4'hF, a, rd, e);
        check("awdly_ack", 32'(a), 32'd1);
        check("awdly_err", 32'(e), 32'd0);
        repeat (3) tick();
        check("awdly_awv_cycles", 32'(awv_cnt), 32'd4);
        check("awdly_wv_cycles", 32'(wv_cnt), 32'd1);
        check("awdly_b_count", 32'(b_cnt), 32'd1);
        check("awdly_reg0", regs[0], 32'h55555555);
        aw_delay = 0;

        // Partial strobe write then read-back
        single(1, 1'b1, 2'd1, 32'hAAAAAAAA, 4'hF, a, rd, e);
        single(1, 1'b1, 2'd1, 32'h12345678, 4'b0011, a, rd, e);
        single(0, 1'b0, 2'd1, 32'h0, 4'h0, a, rd, e);
        check("strb_rdata", rd, 32'hAAAA5678);

        // Error response then a clean one
        r_err_inj = 1'b1;
        single(0, 1'b0, 2'd3, 32'h0, 4'h0, a, rd, e);
        check("rerr_ack", 32'(a), 32'd1);
        check("rerr_err", 32'(e), 32'd1);
        r_err_inj = 1'b0;
        single(1, 1'b0, 2'd3, 32'h0, 4'h0, a, rd, e);
        check("rok_ack", 32'(a), 32'd2);
        check("rok_err", 32'(e), 32'd0);
        check("rok_rdata", rd, 32'h44444444);

        // Reset while waiting in RDATA
        tick();
        set_req(1, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0);
        tick();
        check("rrst_arvalid", 32'(axi.arvalid), 32'd1);
        tick();
        check("rrst_rready", 32'(axi.rready), 32'd1);
        #3;
        rst          = 1'b1;
        req_valid[1] = 1'b0;
        #1;
        check("rrst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
        check("rrst_ack", 32'({req_ack, req_err}), 32'd0);
        tick();
        rst    = 1'b0;
        ack_or = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            ack_or = ack_or | req_ack;
        end
        check("rrst_no_ack", 32'(ack_or), 32'd0);
        single(0, 1'b0, 2'd2, 32'h0, 4'h0, a, rd, e);
        check("post_rst_ack", 32'(a), 32'd1);
        check("post_rst_rdata", rd, 32'hDEADBEEF);
        check("post_rst_err", 32'(e), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_arbiter.md
# axil_reg_arbiter

Shares one AXI4-Lite master port between two simple request/acknowledge requesters, so that a CPU-side port and a DMA/config sequencer can both access the 4×32-bit `axi_slave` register block. The block sequences each access as a full AXI4-Lite write (AW+W → B) or read (AR → R) transaction. It arbitrates round-robin and carries at most one transaction in flight. It sits directly in front of the register slave.

## Interface
- `C_AXI_DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `C_AXI_ADDR_WIDTH`, 2: address width.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  reset, asynchronous and active-high.
- `i_req_valid`  in  2  per-requester request; bit n belongs to requester n.
- `i_req_we`  in  2  1 = write, 0 = read.
- `i_req_addr`  in  2*AW  requester n address in slice `[n*AW +: AW]`.
- `i_req_wdata`  in  2*DW  write data, sliced the same way.
- `i_req_wstrb`  in  2*DW/8  byte strobes, sliced the same way.
- `o_req_ack`  out  2  one-cycle completion pulse for requester n.
- `o_req_err`  out  1  valid with `o_req_ack`; 1 when response ≠ OKAY.
- `o_req_rdata`  out  DW  read data; valid with `o_req_ack` for reads.
- `o_axi_awvalid`/`i_axi_awready`/`o_axi_awaddr[AW]`/`o_axi_awprot[3]`: write address channel.
- `o_axi_wvalid`/`i_axi_wready`/`o_axi_wdata[DW]`/`o_axi_wstrb[DW/8]`: write data channel.
- `i_axi_bvalid`/`o_axi_bready`/`i_axi_bresp[2]`: write response channel.
- `o_axi_arvalid`/`i_axi_arready`/`o_axi_araddr[AW]`/`o_axi_arprot[3]`: read address channel.
- `i_axi_rvalid`/`o_axi_rready`/`i_axi_rdata[DW]`/`i_axi_rresp[2]`: read data channel.

## Operation
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
- **IDLE**
  - If any `i_req_valid` is set, grant one requester.
  - Latch its we/addr/wdata/wstrb into holding registers.
  - Go to WRITE if we=1, otherwise RADDR.
- **Round-robin:** a `last_grant` bit records the last winner.
  - If both requesters are valid, the other requester wins.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **WRITE**
  - Assert awvalid and wvalid together.
  - Each valid deasserts independently on its own handshake; track each with its own "done" flag.
  - Go to WRESP once both handshakes have occurred, including when they occur in the same cycle or on different cycles.
- **WRESP**
  - Hold `o_axi_bready`=1.
  - On bvalid: pulse `o_req_ack[g]`, set err = (bresp≠2'b00), return to IDLE.
- **RADDR:** assert arvalid; on arready go to RDATA.
- **RDATA**
  - Hold `o_axi_rready`=1.
  - On rvalid: register rdata, pulse ack, set err = (rresp≠2'b00), return to IDLE.
- Outputs are fixed: awprot = arprot = 3'b000.
- Requester contract: keep `i_req_valid` and the payload stable until `o_req_ack`, then drop `i_req_valid` the following cycle or issue a new request.
  - The block ignores the granted requester's `i_req_valid` for 1 cycle after ack, so a held request is not re-granted.
- A requester that drops its request before it is granted is simply not served. Dropping after grant has no effect; the transaction completes.

## Timing
- Reset values: every `o_axi_*valid`, bready, rready, `o_req_ack` and `o_req_err` = 0; `o_req_rdata`, addr, data and strb = 0; state IDLE; done flags cleared.
- Reset asserted mid-transaction aborts immediately: all valids drop asynchronously and the pending ack is never issued.
- All outputs are registered; nothing combinational runs from an AXI input to an AXI output.
- Write with zero-wait slave:
  - req seen in cycle 0;
  - aw/wvalid high in cycle 1;
  - bvalid accepted in cycle 2 at the earliest;
  - ack in cycle 3.
- Read latency follows the same pattern: ack in cycle 3 minimum.
- Back-to-back: a new grant can occur in the cycle after ack, giving a minimum of 4 cycles per transaction.
- No cycle limit on slave stalls; the FSM waits indefinitely.

## Structure
- Shared package/header `axil_pkg`:
  - FSM state encodings;
  - `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10;
  - `AXI_PROT_DEFAULT`=3'b000.
- Sub-module `rr_arbiter2`:
  - inputs: `req[1:0]`, `advance`, `i_clk`, `i_reset`;
  - outputs: one-hot `grant[1:0]` and an internal `last_grant` register;
  - reused elsewhere for other two-port sharing.

## Test plan
- Requester 0 writes addr 2, data 0xDEADBEEF, wstrb 4'hF, zero-wait slave → aw/w handshakes in cycle 1, `o_req_ack`=2'b01 in cycle 3, err=0; slave reg_2=0xDEADBEEF.
- Both requesters read simultaneously after reset, addr 1 and addr 3 → requester 0 acked first, then requester 1; rdata matches each register; the third contention goes to requester 0.
- Slave delays awready by 3 cycles while accepting wready immediately → wvalid drops after 1 cycle, awvalid is held 4 cycles, and exactly one B is consumed.
- Write with wstrb 4'b0011, data 0x12345678 over 0xAAAAAAAA → read-back yields 0xAAAA5678.
- Slave returns rresp=2'b10 → ack with `o_req_err`=1; next transaction reports err=0.
- Assert `i_reset` while in RDATA → all valids/readies are 0 in the same cycle, no ack is produced, and the block returns to IDLE and serves a new request normally.
